edge_pulse_gen: RTL

EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

---
 rtl/edge_pulse_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: for each accepted trigger, produces a registered pulse on
// oWire that is HIGH_CYC cycles high followed by at least LOW_CYC cycles low.
// Because each pulse is followed by a guaranteed low gap, a two-flop rising
// edge detector on the same clock sees every generated pulse.
//
// Build option: define EDGE_PULSE_GEN_QUEUE_EN to enable a pending-trigger
// counter. A trigger that arrives while a pulse is in progress is then queued
// and replayed back-to-back. Without the macro such a trigger is dropped and
// oOverflow is set. The one exception is the final LOW cycle, where a
// concurrent trigger starts the next pulse directly.
module edge_pulse_gen #(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 4,
    parameter int CNT_W    = 8,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iTrig,
    input  logic              iClr,
    output logic              oWire,
    output logic              oBusy,
    output logic [PEND_W-1:0] oPend,
    output logic              oOverflow
);

    // Counter load values: the counter counts down to zero, so a phase of N
    // cycles starts from N-1.
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wire_q;
    logic             busy_q;
    logic             ovf_q, ovf_d;
    logic             trig_taken;   // iTrig this cycle starts a pulse directly

`ifdef EDGE_PULSE_GEN_QUEUE_EN
    localparam logic [PEND_W-1:0] MAX_PEND = '1;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              pend_start;  // a queued trigger is consumed this cycle
`endif

    // Next-state logic for the phase FSM, the pending queue and the sticky
    // overflow flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        // A clear request drops the flag, but a new overflow in the same
        // cycle sets it again below, so the set takes priority.
        ovf_d      = ovf_q & ~iClr;
        trig_taken = 1'b0;
`ifdef EDGE_PULSE_GEN_QUEUE_EN
        pend_d     = pend_q;
        pend_start = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (iTrig) begin
                    state_d    = ST_HIGH;
                    cnt_d      = HIGH_LOAD;
                    trig_taken = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
`ifdef EDGE_PULSE_GEN_QUEUE_EN
                    if (pend_q != '0) begin
                        state_d    = ST_HIGH;
                        cnt_d      = HIGH_LOAD;
                        pend_start = 1'b1;
                    end else
`endif
                    if (iTrig) begin
                        state_d    = ST_HIGH;
                        cnt_d      = HIGH_LOAD;
                        trig_taken = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A trigger not taken directly can only occur while busy.
`ifdef EDGE_PULSE_GEN_QUEUE_EN
        if (iTrig && !trig_taken) begin
            // When a queued trigger is consumed in the same cycle, the new one
            // takes its slot and the count stays unchanged.
            if (!pend_start) begin
                if (pend_q == MAX_PEND) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end
        end else if (pend_start) begin
            pend_d = pend_q - PEND_W'(1);
        end
`else
        if (iTrig && !trig_taken) begin
            ovf_d = 1'b1;
        end
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wire_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef EDGE_PULSE_GEN_QUEUE_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wire_q  <= (state_d == ST_HIGH);
            busy_q  <= (state_d != ST_IDLE);
            ovf_q   <= ovf_d;
`ifdef EDGE_PULSE_GEN_QUEUE_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign oWire     = wire_q;
    assign oBusy     = busy_q;
    assign oOverflow = ovf_q;
`ifdef EDGE_PULSE_GEN_QUEUE_EN
    assign oPend     = pend_q;
`else
    assign oPend     = '0;
`endif

endmodule
